// File: rtl/sparc_pkg.sv
// Shared types and the logical-to-physical register mapping for the windowed SPARC register file.
package sparc_pkg;
    localparam int NWINDOWS  = 8;
    localparam int REG_W     = 32;
    localparam int MAX_CWPW  = 5;
    localparam int PIDX_W    = 10;

    typedef logic [MAX_CWPW-1:0] cwp_t;
    typedef logic [PIDX_W-1:0]   phys_idx_t;

    // Ins of window w alias the outs of window w+1, so the caller's outs become the callee's ins.
    function automatic phys_idx_t rf_phys_idx(input logic [4:0] r, input cwp_t cwp, input int nwin);
        int w;
        w = int'(cwp);
        if (r < 5'd8)
            return phys_idx_t'(r);
        else if (r < 5'd24)
            return phys_idx_t'(8 + 16*w + int'(r) - 8);
        else
            return phys_idx_t'(8 + 16*((w + 1) % nwin) + int'(r) - 24);
    endfunction
endpackage

// File: rtl/rf_bypass_read.sv
// One read port: map logical address through CWP, read the flop array, forward same-cycle writes.
module rf_bypass_read
    import sparc_pkg::*;
#(
    parameter int NWINDOWS = 8,
    parameter int REG_W    = 32,
    localparam int NPHYS   = 8 + 16*NWINDOWS,
    localparam int IW      = $clog2(NPHYS)
) (
    input  logic [NPHYS-1:0][REG_W-1:0] regs,
    input  logic [4:0]                  addr,
    input  cwp_t                        cwp,
    input  logic [1:0]                  wr_en,
    input  phys_idx_t [1:0]             wr_idx,
    input  logic [1:0][REG_W-1:0]       wr_data,
    output logic [REG_W-1:0]            data
);
    phys_idx_t      idx;
    logic [IW-1:0]  ridx;

    always_comb begin
        idx  = rf_phys_idx(addr, cwp, NWINDOWS);
        ridx = idx[IW-1:0];
        data = regs[ridx];
        for (int k = 0; k < 2; k++)
            if (wr_en[k] && wr_idx[k] == idx)
                data = wr_data[k];
        // g0 is hardwired; the write side never targets it, but keep the read side honest too
        if (idx == '0)
            data = '0;
    end
endmodule

// File: rtl/sparc_regfile.sv
// Windowed SPARC integer register file: WB write side, ID read side with write-through, CWP/WIM.
module sparc_regfile
    import sparc_pkg::*;
#(
    parameter int NWINDOWS = sparc_pkg::NWINDOWS,
    parameter int REG_W    = sparc_pkg::REG_W,
    localparam int CWPW    = $clog2(NWINDOWS),
    localparam int NPHYS   = 8 + 16*NWINDOWS,
    localparam int IW      = $clog2(NPHYS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2*REG_W-1:0]   WB_data_in,
    input  logic [4:0]           WB_regD_in,
    input  logic [CWPW-1:0]      WB_cwp_in,
    input  logic                 WB_reg_en,
    input  logic                 WB_regDouble_en,
    input  logic [4:0]           ID_rs1_in,
    input  logic [4:0]           ID_rs2_in,
    input  logic [4:0]           ID_rd_in,
    output logic [REG_W-1:0]     ID_rs1_out,
    output logic [REG_W-1:0]     ID_rs2_out,
    output logic [2*REG_W-1:0]   ID_rd_out,
    input  logic                 ID_save_in,
    input  logic                 ID_restore_in,
    input  logic                 wim_we_in,
    input  logic [NWINDOWS-1:0]  wim_data_in,
    output logic [CWPW-1:0]      cwp_out,
    output logic [NWINDOWS-1:0]  wim_out,
    output logic                 win_overflow_out,
    output logic                 win_underflow_out
);
    logic [NPHYS-1:0][REG_W-1:0] regs;
    logic [CWPW-1:0]             cwp;
    logic [NWINDOWS-1:0]         wim;
    logic                        overflow, underflow;

    logic [4:0]                  rd_a, rd_b;
    logic [1:0]                  wr_en;
    phys_idx_t [1:0]             wr_idx;
    logic [1:0][REG_W-1:0]       wr_data;

    // Port 0 carries single writes or the even half of a double; port 1 the odd half.
    always_comb begin
        rd_a       = WB_regD_in;
        rd_b       = WB_regD_in | 5'd1;
        wr_en      = '0;
        wr_data[0] = WB_data_in[REG_W-1:0];
        wr_data[1] = WB_data_in[REG_W-1:0];
        if (WB_regDouble_en) begin
            rd_a       = WB_regD_in & 5'b11110;
            wr_data[0] = WB_data_in[2*REG_W-1:REG_W];
            wr_en[0]   = (rd_a != 5'd0);
            wr_en[1]   = 1'b1;
        end else if (WB_reg_en) begin
            wr_en[0]   = (WB_regD_in != 5'd0);
        end
        wr_idx[0] = rf_phys_idx(rd_a, cwp_t'(WB_cwp_in), NWINDOWS);
        wr_idx[1] = rf_phys_idx(rd_b, cwp_t'(WB_cwp_in), NWINDOWS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (wr_en[k])
                    regs[wr_idx[k][IW-1:0]] <= wr_data[k];
        end
    end

    logic [CWPW-1:0] cwp_save, cwp_rest;
    assign cwp_save = cwp - 1'b1;
    assign cwp_rest = cwp + 1'b1;

    // The window check uses the WIM held before any same-cycle WRWIM.
    always_ff @(posedge clk) begin
        if (reset) begin
            cwp       <= '0;
            wim       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (ID_save_in && !ID_restore_in) begin
                if (wim[cwp_save]) overflow <= 1'b1;
                else               cwp      <= cwp_save;
            end else if (ID_restore_in && !ID_save_in) begin
                if (wim[cwp_rest]) underflow <= 1'b1;
                else               cwp       <= cwp_rest;
            end
            if (wim_we_in)
                wim <= wim_data_in;
        end
    end

    sr_exclusive: assert property (@(posedge clk) disable iff (reset) !(ID_save_in && ID_restore_in));

    logic [3:0][4:0]       rp_addr;
    logic [3:0][REG_W-1:0] rp_data;

    assign rp_addr[0] = ID_rs1_in;
    assign rp_addr[1] = ID_rs2_in;
    assign rp_addr[2] = ID_rd_in & 5'b11110;
    assign rp_addr[3] = ID_rd_in | 5'd1;

    for (genvar p = 0; p < 4; p++) begin : g_rd
        rf_bypass_read #(.NWINDOWS(NWINDOWS), .REG_W(REG_W)) u_rd (
            .regs    (regs),
            .addr    (rp_addr[p]),
            .cwp     (cwp_t'(cwp)),
            .wr_en   (wr_en),
            .wr_idx  (wr_idx),
            .wr_data (wr_data),
            .data    (rp_data[p])
        );
    end

    assign ID_rs1_out        = rp_data[0];
    assign ID_rs2_out        = rp_data[1];
    assign ID_rd_out         = {rp_data[2], rp_data[3]};
    assign cwp_out           = cwp;
    assign wim_out           = wim;
    assign win_overflow_out  = overflow;
    assign win_underflow_out = underflow;
endmodule
